wb_master_bridge: RTL
=====================

Name: wb_master_bridge

Overview:
Parametrised bridge from the SCR1-side simple request/response memory port to a Wishbone classic master. It generalises the single-transaction WB master with configurable address/data width, a one-entry request buffer that accepts the next request while a bus cycle is in flight, Wishbone error termination, and a bus timeout. It sits between the core memory interface and the Wishbone interconnect.

Parameters:
ADDR_W, 32, address width of request and wbm_adr_o
DATA_W, 32, data width (multiple of 8); SEL_W = DATA_W/8
TIMEOUT_CYCLES, 256, max cycles stb may stay high without ack/err; 0 disables timeout
TO_CNT_W, 9, timeout counter width, >= clog2(TIMEOUT_CYCLES+1)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid & ready
req_addr_i  in  ADDR_W  request address
req_we_i  in  1  1=write, 0=read
req_be_i  in  SEL_W  byte enables (write); ignored for reads
req_wdata_i  in  DATA_W  write data
resp_valid_o  out  1  one-cycle response pulse, no backpressure
resp_rdata_o  out  DATA_W  read data (0 on error/write)
resp_err_o  out  1  response is bus error or timeout
wbm_adr_o  out  ADDR_W  WB address
wbm_dat_o  out  DATA_W  WB write data
wbm_dat_i  in  DATA_W  WB read data
wbm_we_o  out  1  WB write enable
wbm_sel_o  out  SEL_W  WB byte select
wbm_stb_o  out  1  WB strobe
wbm_cyc_o  out  1  WB cycle
wbm_ack_i  in  1  WB ack
wbm_err_i  in  1  WB error

Behaviour:
- Clock wb_clk_i; reset wb_rst_i synchronous, active-high.
- Reset: all wbm_* outputs 0, resp_valid_o/resp_err_o 0, resp_rdata_o 0, buffer empty, state IDLE, timeout counter 0; req_ready_o 1 from first cycle after reset.
- Reset mid-transaction: cyc/stb drop at that edge, buffer discarded, no response issued.
- req_ready_o = buffer empty (combinational from registered flag). Accept only on req_valid_i & req_ready_o.
- States: IDLE, BUS, RESP.
- IDLE: accepted request (or buffered one) is launched: next cycle cyc=stb=1, adr/we/dat driven; sel = req_be_i for writes, all-ones for reads. Request accepted in cycle N -> cyc/stb high in N+1.
- BUS: outputs held stable. Another request may be accepted into the buffer (req_ready_o high while buffer empty).
  - ack or err sampled high in cycle M -> cyc/stb/we = 0 in M+1; resp_valid_o = 1 in M+1 only; enter RESP.
  - resp_err_o = wbm_err_i; resp_rdata_o = wbm_dat_i on read ack, else 0.
  - ack and err both high: treat as error.
  - Timeout (TIMEOUT_CYCLES>0): counter increments each BUS cycle without ack/err; if the TIMEOUT_CYCLES-th stb cycle has neither, terminate as error (resp_err_o=1, rdata 0) next cycle.
- RESP: one idle bus cycle (cyc=0) after every transaction. If buffer full, launch it (cyc high in M+2) and free buffer; else go IDLE.
- Requests accepted in IDLE go straight to the bus and never occupy the buffer. At most one in flight plus one buffered; responses in request order.
- resp_rdata_o/resp_err_o hold their value outside resp_valid_o pulses; only valid with the pulse.
- Timeout counter clears on every launch.

Test Plan:
- Read: req addr 0x100, we=0 at cycle 0; ack at cycle 3 with dat 0xDEADBEEF -> cyc/stb 1-3, sel=0xF, we=0; resp_valid cycle 4, rdata 0xDEADBEEF, err 0.
- Write: addr 0x204, be=0x3, wdata 0x0000A5A5 -> wbm_sel 0x3, we 1, dat_o 0x0000A5A5; response after ack with rdata 0, err 0.
- Back-to-back: 2nd request accepted while 1st in BUS (req_ready then 0 for a 3rd); 1st ack at M -> 2nd cyc rises at M+2 with 2nd address; responses in order.
- Error: wbm_err_i (with ack) at 2nd stb cycle -> resp_err 1, rdata 0, cyc drops next cycle.
- Timeout: TIMEOUT_CYCLES=4, no ack -> stb high exactly 4 cycles, resp_valid with err 1 the cycle after.
- Reset mid-BUS with buffer full: cyc/stb 0 after edge, no resp_valid, req_ready 1 next cycle, next request runs normally.

Source files
------------

// File: rtl/wb_master_bridge.sv
// wb_master_bridge
//   Bridges a simple valid/ready request port with a one-cycle response pulse
//   onto a Wishbone classic master. One bus cycle can be in flight while a
//   second request waits in a one-entry buffer. A bus cycle ends on ack, on
//   err, or when stb has been high for TIMEOUT_CYCLES cycles with no answer.
//   Every bus cycle is followed by one idle cycle with cyc low.
//
//   State | meaning
//   IDLE  | no bus cycle, buffer empty
//   BUS   | cyc/stb high, waiting for ack/err/timeout
//   RESP  | response pulse cycle, bus idle; launches buffered request if any
//
// Ports
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   req_valid_i/req_ready_o request handshake; ready = buffer empty
//   req_addr_i, req_we_i    request address and direction
//   req_be_i, req_wdata_i   write byte enables and data
//   resp_valid_o            one-cycle response pulse
//   resp_rdata_o/resp_err_o response data and error flag, held between pulses
//   wbm_*                   Wishbone classic master signals
module wb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TO_CNT_W       = 9
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic                  req_we_i,
  input  logic [DATA_W/8-1:0]   req_be_i,
  input  logic [DATA_W-1:0]     req_wdata_i,
  output logic                  resp_valid_o,
  output logic [DATA_W-1:0]     resp_rdata_o,
  output logic                  resp_err_o,
  output logic [ADDR_W-1:0]     wbm_adr_o,
  output logic [DATA_W-1:0]     wbm_dat_o,
  input  logic [DATA_W-1:0]     wbm_dat_i,
  output logic                  wbm_we_o,
  output logic [DATA_W/8-1:0]   wbm_sel_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_cyc_o,
  input  logic                  wbm_ack_i,
  input  logic                  wbm_err_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              buf_vld_q, buf_vld_d;
  logic [ADDR_W-1:0] buf_adr_q, buf_adr_d;
  logic              buf_we_q, buf_we_d;
  logic [SEL_W-1:0]  buf_sel_q, buf_sel_d;
  logic [DATA_W-1:0] buf_dat_q, buf_dat_d;

  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              we_q, we_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              cyc_q, cyc_d;

  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

  logic              resp_vld_q, resp_vld_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic             accept;
  logic             bus_done;
  logic             timeout_hit;
  logic             terminate;
  logic             launch_buf;
  logic             launch_req;
  logic [SEL_W-1:0] req_sel;

  assign req_ready_o = ~buf_vld_q;
  assign accept      = req_valid_i & req_ready_o;
  assign bus_done    = wbm_ack_i | wbm_err_i;
  // to_cnt_q counts completed silent stb cycles, so the last allowed stb
  // cycle is the one where it reads TIMEOUT_CYCLES-1. An answer in that same
  // cycle still wins over the timeout.
  assign timeout_hit = TO_EN && (to_cnt_q == TO_LAST) && !bus_done;
  assign terminate   = (state_q == ST_BUS) && (bus_done || timeout_hit);
  assign launch_buf  = (state_q == ST_RESP) && buf_vld_q;
  // A request arriving in RESP with an empty buffer goes straight out, which
  // still keeps the mandatory idle cycle.
  assign launch_req  = accept && ((state_q == ST_IDLE) || (state_q == ST_RESP));
  assign req_sel     = req_we_i ? req_be_i : {SEL_W{1'b1}};

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUS;
      ST_BUS:  if (terminate) state_d = ST_RESP;
      ST_RESP: state_d = (buf_vld_q || accept) ? ST_BUS : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    buf_vld_d    = buf_vld_q;
    buf_adr_d    = buf_adr_q;
    buf_we_d     = buf_we_q;
    buf_sel_d    = buf_sel_q;
    buf_dat_d    = buf_dat_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    we_d         = we_q;
    sel_d        = sel_q;
    cyc_d        = cyc_q;
    to_cnt_d     = to_cnt_q;
    resp_vld_d   = 1'b0;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    if (launch_buf) begin
      adr_d     = buf_adr_q;
      dat_d     = buf_dat_q;
      we_d      = buf_we_q;
      sel_d     = buf_sel_q;
      cyc_d     = 1'b1;
      to_cnt_d  = '0;
      buf_vld_d = 1'b0;
    end else if (launch_req) begin
      adr_d    = req_addr_i;
      dat_d    = req_wdata_i;
      we_d     = req_we_i;
      sel_d    = req_sel;
      cyc_d    = 1'b1;
      to_cnt_d = '0;
    end

    if (state_q == ST_BUS) begin
      if (accept) begin
        buf_vld_d = 1'b1;
        buf_adr_d = req_addr_i;
        buf_we_d  = req_we_i;
        buf_sel_d = req_sel;
        buf_dat_d = req_wdata_i;
      end
      if (terminate) begin
        cyc_d        = 1'b0;
        we_d         = 1'b0;
        resp_vld_d   = 1'b1;
        // Timeout reports as error; err wins over a simultaneous ack.
        resp_err_d   = !bus_done || wbm_err_i;
        resp_rdata_d = (bus_done && !wbm_err_i && !we_q) ? wbm_dat_i : '0;
      end else if (TO_EN) begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      buf_vld_q    <= 1'b0;
      buf_adr_q    <= '0;
      buf_we_q     <= 1'b0;
      buf_sel_q    <= '0;
      buf_dat_q    <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      cyc_q        <= 1'b0;
      to_cnt_q     <= '0;
      resp_vld_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      buf_vld_q    <= buf_vld_d;
      buf_adr_q    <= buf_adr_d;
      buf_we_q     <= buf_we_d;
      buf_sel_q    <= buf_sel_d;
      buf_dat_q    <= buf_dat_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      we_q         <= we_d;
      sel_q        <= sel_d;
      cyc_q        <= cyc_d;
      to_cnt_q     <= to_cnt_d;
      resp_vld_q   <= resp_vld_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;
  assign wbm_we_o     = we_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign resp_valid_o = resp_vld_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule
